// File: rtl/q4_lsu.sv
// q4 load/store unit: turns load/store control into a req/gnt/rvalid data-bus
// transaction and returns aligned, extended load data to the q4q5 register.
module q4_lsu #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_mem_read,
    input  logic        i_mem_write,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_mem_rdata,
    output logic        o_stall,
    output logic        o_misaligned,
    output logic        o_bus_err,
    output logic        o_dbus_req,
    output logic        o_dbus_we,
    output logic [31:0] o_dbus_addr,
    output logic [31:0] o_dbus_wdata,
    output logic [3:0]  o_dbus_be,
    input  logic        i_dbus_gnt,
    input  logic        i_dbus_rvalid,
    input  logic [31:0] i_dbus_rdata
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

    state_t        state, state_nxt;
    logic          access, is_byte, is_half, misalign, aligned_access;
    logic [3:0]    be_comb;
    logic [31:0]   wdata_comb;
    logic [29:0]   lat_addr;
    logic [1:0]    lat_off;
    logic [2:0]    lat_f3;
    logic          lat_we;
    logic [3:0]    lat_be;
    logic [31:0]   lat_wdata;
    logic [CW-1:0] cnt;
    logic          busy, timeout, resp_ok, timeout_fire;
    logic [31:0]   shifted, ld_fmt;

    assign access         = i_mem_read | i_mem_write;
    assign is_byte        = (i_funct3[1:0] == 2'b00);
    assign is_half        = (i_funct3[1:0] == 2'b01);
    assign misalign       = (is_half & i_addr[0]) | (i_funct3[1] & (i_addr[1:0] != 2'b00));
    assign aligned_access = access & ~misalign;
    assign o_misaligned   = access & misalign;

    always_comb begin
        be_comb    = 4'b1111;
        wdata_comb = i_wdata;
        if (is_byte) begin
            be_comb    = 4'b0001 << i_addr[1:0];
            wdata_comb = {4{i_wdata[7:0]}};
        end else if (is_half) begin
            be_comb    = i_addr[1] ? 4'b1100 : 4'b0011;
            wdata_comb = {2{i_wdata[15:0]}};
        end
    end

    // In IDLE the request goes out combinationally; afterwards the latched copy keeps it stable.
    assign o_dbus_addr  = (state == IDLE) ? {i_addr[31:2], 2'b00} : {lat_addr, 2'b00};
    assign o_dbus_we    = (state == IDLE) ? i_mem_write : lat_we;
    assign o_dbus_be    = (state == IDLE) ? be_comb : lat_be;
    assign o_dbus_wdata = (state == IDLE) ? wdata_comb : lat_wdata;

    assign busy         = (state == REQ) || (state == RESP);
    assign timeout      = busy && (cnt >= CW'(TIMEOUT_CYCLES - 1));
    assign resp_ok      = (state == RESP) && i_dbus_rvalid;
    assign timeout_fire = timeout && !resp_ok;

    always_comb begin
        state_nxt  = state;
        o_dbus_req = 1'b0;
        o_stall    = 1'b0;
        case (state)
            IDLE: begin
                if (aligned_access) begin
                    o_dbus_req = 1'b1;
                    o_stall    = 1'b1;
                    state_nxt  = i_dbus_gnt ? RESP : REQ;
                end
            end
            REQ: begin
                o_dbus_req = 1'b1;
                o_stall    = 1'b1;
                if (timeout)         state_nxt = DONE;
                else if (i_dbus_gnt) state_nxt = RESP;
            end
            RESP: begin
                o_stall = 1'b1;
                if (i_dbus_rvalid || timeout) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign shifted = i_dbus_rdata >> {lat_off, 3'b000};

    always_comb begin
        ld_fmt = shifted;
        case (lat_f3[1:0])
            2'b00:   ld_fmt = {{24{~lat_f3[2] & shifted[7]}}, shifted[7:0]};
            2'b01:   ld_fmt = {{16{~lat_f3[2] & shifted[15]}}, shifted[15:0]};
            default: ld_fmt = shifted;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            o_mem_rdata <= '0;
            o_bus_err   <= 1'b0;
            lat_addr    <= '0;
            lat_off     <= '0;
            lat_f3      <= '0;
            lat_we      <= 1'b0;
            lat_be      <= '0;
            lat_wdata   <= '0;
        end else begin
            state     <= state_nxt;
            o_bus_err <= timeout_fire;
            if (state == IDLE && aligned_access) begin
                lat_addr  <= i_addr[31:2];
                lat_off   <= i_addr[1:0];
                lat_f3    <= i_funct3;
                lat_we    <= i_mem_write;
                lat_be    <= be_comb;
                lat_wdata <= wdata_comb;
            end
            if (!busy)
                cnt <= '0;
            else if (cnt != CW'(TIMEOUT_CYCLES))
                cnt <= cnt + CW'(1);
            if (resp_ok && !lat_we)
                o_mem_rdata <= ld_fmt;
            else if (timeout_fire)
                o_mem_rdata <= '0;
        end
    end
endmodule

// File: tb/tb_q4_lsu.sv
// Scoreboard bench for q4_lsu: each access pushes its expected writeback value,
// which is popped and compared once the stall releases.
module tb_q4_lsu;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_read = 1'b0, mem_write = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] addr = '0, wdata = '0;
    logic        dbus_gnt = 1'b0, dbus_rvalid = 1'b0;
    logic [31:0] dbus_rdata = '0;
    logic [31:0] mem_rdata, dbus_addr, dbus_wdata;
    logic        stall, misaligned, bus_err, dbus_req, dbus_we;
    logic [3:0]  dbus_be;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    int          n_run = 0;
    int          n_fail = 0;
    logic [31:0] model_rdata = '0;

    q4_lsu #(.TIMEOUT_CYCLES(4)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_mem_read(mem_read), .i_mem_write(mem_write), .i_funct3(funct3),
        .i_addr(addr), .i_wdata(wdata),
        .o_mem_rdata(mem_rdata), .o_stall(stall), .o_misaligned(misaligned),
        .o_bus_err(bus_err), .o_dbus_req(dbus_req), .o_dbus_we(dbus_we),
        .o_dbus_addr(dbus_addr), .o_dbus_wdata(dbus_wdata), .o_dbus_be(dbus_be),
        .i_dbus_gnt(dbus_gnt), .i_dbus_rvalid(dbus_rvalid), .i_dbus_rdata(dbus_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ld_model(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        b = d[int'(off)*8 +: 8];
        h = off[1] ? d[31:16] : d[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b100:  return {24'h0, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b101:  return {16'h0, h};
            default: return d;
        endcase
    endfunction

    // gnt arrives gdel cycles after the request starts, rvalid the cycle after gnt.
    task automatic do_access(input string name, input logic rd, input logic wr,
                             input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                             input int gdel, input logic give_rv, input logic [31:0] rdat,
                             input int exp_stall, input logic [3:0] exp_be,
                             input logic [31:0] exp_wdata);
        exp_t e;
        int   stalls = 0;
        int   reqs = 0;
        bit   done = 0;
        @(negedge clk);
        mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = wd;
        if (!give_rv)  model_rdata = '0;
        else if (!wr)  model_rdata = ld_model(f3, a[1:0], rdat);
        e.rdata = model_rdata;
        e.err   = !give_rv;
        sb.push_back(e);
        for (int c = 0; c < 40; c++) begin
            dbus_gnt    = (c == gdel);
            dbus_rvalid = give_rv && (c == gdel + 1);
            dbus_rdata  = dbus_rvalid ? rdat : 32'h0;
            #1;
            if (!stall) begin
                done = 1;
                break;
            end
            stalls++;
            if (dbus_req) begin
                reqs++;
                chk({name, "_addr"}, dbus_addr, {a[31:2], 2'b00});
                chk({name, "_be"}, {28'h0, dbus_be}, {28'h0, exp_be});
                chk({name, "_wdata"}, dbus_wdata, exp_wdata);
                chk({name, "_we"}, {31'h0, dbus_we}, {31'h0, wr});
            end
            @(negedge clk);
        end
        chk({name, "_completed"}, {31'h0, done}, 32'h1);
        e = sb.pop_front();
        chk({name, "_rdata"}, mem_rdata, e.rdata);
        chk({name, "_bus_err"}, {31'h0, bus_err}, {31'h0, e.err});
        chk({name, "_stall_cycles"}, stalls, exp_stall);
        chk({name, "_req_cycles"}, reqs, gdel + 1);
        mem_read = 1'b0; mem_write = 1'b0; dbus_gnt = 1'b0; dbus_rvalid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        #1;
        chk("rst_stall", {31'h0, stall}, 32'h0);
        chk("rst_req", {31'h0, dbus_req}, 32'h0);
        chk("rst_rdata", mem_rdata, 32'h0);
        chk("rst_bus_err", {31'h0, bus_err}, 32'h0);
        rst_n = 1'b1;

        do_access("lw",  1, 0, 3'b010, 32'h100, 32'h11111111, 0, 1, 32'hDEADBEEF, 2, 4'b1111, 32'h11111111);
        do_access("lb",  1, 0, 3'b000, 32'h103, 32'h0, 0, 1, 32'h80000000, 2, 4'b1000, 32'h0);
        do_access("lbu", 1, 0, 3'b100, 32'h103, 32'h0, 0, 1, 32'h80000000, 2, 4'b1000, 32'h0);
        do_access("sh",  0, 1, 3'b001, 32'h202, 32'h1234ABCD, 3, 1, 32'h0, 5, 4'b1100, 32'hABCDABCD);
        do_access("lh",  1, 0, 3'b001, 32'h102, 32'h0, 1, 1, 32'h80011234, 3, 4'b1100, 32'h0);
        do_access("lhu", 1, 0, 3'b101, 32'h100, 32'h0, 0, 1, 32'h8001F234, 2, 4'b0011, 32'h0);
        do_access("sb_rw", 1, 1, 3'b000, 32'h301, 32'h000000A5, 0, 1, 32'h0, 2, 4'b0010, 32'hA5A5A5A5);

        // Misaligned accesses never reach the bus.
        @(negedge clk);
        mem_read = 1'b1; funct3 = 3'b010; addr = 32'h101;
        #1;
        chk("mis_lw_flag", {31'h0, misaligned}, 32'h1);
        chk("mis_lw_req", {31'h0, dbus_req}, 32'h0);
        chk("mis_lw_stall", {31'h0, stall}, 32'h0);
        @(negedge clk);
        mem_read = 1'b0; mem_write = 1'b1; funct3 = 3'b001; addr = 32'h203;
        #1;
        chk("mis_sh_flag", {31'h0, misaligned}, 32'h1);
        chk("mis_sh_req", {31'h0, dbus_req}, 32'h0);
        chk("mis_rdata_kept", mem_rdata, model_rdata);
        mem_write = 1'b0;
        #1;
        chk("mis_no_access", {31'h0, misaligned}, 32'h0);

        do_access("timeout", 1, 0, 3'b010, 32'h400, 32'h0, 0, 0, 32'h0, 5, 4'b1111, 32'h0);
        @(negedge clk);
        #1;
        chk("timeout_err_single", {31'h0, bus_err}, 32'h0);
        chk("timeout_idle", {31'h0, stall}, 32'h0);

        do_access("lw2", 1, 0, 3'b010, 32'h104, 32'h0, 0, 1, 32'hCAFEF00D, 2, 4'b1111, 32'h0);

        // Reset while a load is waiting in RESP, then a late response.
        @(negedge clk);
        mem_read = 1'b1; funct3 = 3'b010; addr = 32'h100; dbus_gnt = 1'b1;
        @(negedge clk);
        dbus_gnt = 1'b0;
        #1;
        chk("midrst_in_resp", {31'h0, stall}, 32'h1);
        mem_read = 1'b0;
        rst_n = 1'b0;
        model_rdata = '0;
        #1;
        chk("midrst_stall", {31'h0, stall}, 32'h0);
        chk("midrst_req", {31'h0, dbus_req}, 32'h0);
        chk("midrst_rdata", mem_rdata, model_rdata);
        chk("midrst_err", {31'h0, bus_err}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        dbus_rvalid = 1'b1; dbus_rdata = 32'h12345678;
        @(negedge clk);
        dbus_rvalid = 1'b0; dbus_rdata = 32'h0;
        #1;
        chk("late_rvalid_stall", {31'h0, stall}, 32'h0);
        chk("late_rvalid_rdata", mem_rdata, model_rdata);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
